// File: rtl/syncfifo_prog.sv
// syncfifo_prog -- single-clock FIFO with generic width/depth, occupancy
// count, programmable almost-full/almost-empty flags and sticky
// overflow/underflow error flags.
//
// Optional build macro: FIFO_FWFT_EN
//   defined   : first-word fall-through; data_out = mem[rd_ptr] whenever
//               !empty, r_en acts as a pop acknowledge.
//   undefined : registered read; data_out is loaded on the edge that
//               accepts a read and is valid the following cycle.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   w_en         in   write request
//   r_en         in   read request
//   data_in      in   [DATA_W-1:0] write data
//   err_clr      in   synchronous clear of overflow/underflow
//   data_out     out  [DATA_W-1:0] read data
//   full         out  count == DEPTH
//   empty        out  count == 0
//   almost_full  out  count >= AF_THRESH
//   almost_empty out  count <= AE_THRESH
//   count        out  [$clog2(DEPTH):0] occupancy 0..DEPTH
//   overflow     out  sticky: a write was rejected
//   underflow    out  sticky: a read was rejected
//
// DEPTH must be a power of 2 and at least 4.

module syncfifo_prog #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   w_en,
    input  logic                   r_en,
    input  logic [DATA_W-1:0]      data_in,
    input  logic                   err_clr,
    output logic [DATA_W-1:0]      data_out,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_nxt;
    logic              wr_ok;
    logic              rd_ok;

    // Handshake: a request is honoured on the rising edge where it is
    // sampled high and the FIFO can take it. A read needs a non-empty FIFO.
    // A write needs room, or a simultaneous read that frees a slot on the
    // same edge (so a full FIFO can stream with w_en and r_en both high).
    // A rejected request has no effect apart from its sticky error flag.
    assign rd_ok = r_en && !empty;
    assign wr_ok = w_en && (!full || r_en);

    always_comb begin
        count_nxt = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Pointers, count and status flags. Flags are registered from the
    // next-state count so they change on the same edge as count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            count        <= count_nxt;
            full         <= (count_nxt == DEPTH_C);
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= AF_C);
            almost_empty <= (count_nxt <= AE_C);
        end
    end

    // Sticky errors: a new error on the same edge as err_clr wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (w_en && full && !r_en) overflow <= 1'b1;
            else if (err_clr)          overflow <= 1'b0;

            if (r_en && empty)         underflow <= 1'b1;
            else if (err_clr)          underflow <= 1'b0;
        end
    end

    // Storage is not reset.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= data_in;
    end

`ifdef FIFO_FWFT_EN
    // Head word is always visible; meaningless while empty.
    assign data_out = mem[rd_ptr];
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     data_out <= '0;
        else if (rd_ok) data_out <= mem[rd_ptr];
    end
`endif

endmodule

// File: doc/syncfifo_prog.md
Name: syncfifo_prog

Overview:
Parametrised successor to the single-clock 8-bit FIFO. Generic width and depth, occupancy count, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags with clear. Sits between producer and consumer blocks in the same clock domain. Ports are a superset of the 8-bit FIFO's ports.

Parameters:
DATA_W, 8, data word width in bits
DEPTH, 16, number of entries; must be a power of 2 and at least 4
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH

Ports:
clk  in  1  clock; all logic on the rising edge
rst_n  in  1  asynchronous active-low reset
w_en  in  1  write request
r_en  in  1  read request
data_in  in  DATA_W  write data
err_clr  in  1  synchronous clear of the sticky error flags
data_out  out  DATA_W  read data
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: a write was rejected
underflow  out  1  sticky: a read was rejected

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Pointers = 0, count = 0, data_out = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0, overflow = 0, underflow = 0.
  - Memory contents are not reset.
  - Reset asserted mid-operation discards all contents immediately.
- Storage and pointers:
  - Storage is DEPTH x DATA_W.
  - Read and write pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - count is held in a separate up/down register; it is not derived from the pointers.
- Acceptance rules:
  - rd_ok = r_en && !empty.
  - wr_ok = w_en && (!full || r_en).
  - When full and both w_en and r_en are high, both are accepted and count is unchanged.
  - When empty and both are high, the write is accepted, the read is rejected, and count goes +1.
- Count update per cycle: +1 if wr_ok only; -1 if rd_ok only; unchanged if both or neither.
- Flags:
  - full, empty, almost_full and almost_empty are registered outputs.
  - They are computed from the next-state count, so they change on the same edge as count.
- Read latency (default mode):
  - On an edge with rd_ok, data_out <= mem[rd_ptr] and rd_ptr increments.
  - Data is therefore valid one cycle after r_en is sampled.
  - data_out holds its value when no read is accepted.
- Write: on an edge with wr_ok, mem[wr_ptr] <= data_in and wr_ptr increments.
- Sticky errors:
  - overflow sets on any edge with w_en && full && !r_en.
  - underflow sets on any edge with r_en && empty.
  - Both flags stay set until err_clr=1 is sampled.
  - If err_clr and a new error occur on the same edge, the flag ends set (set wins).
- Rejected operations change no pointer, no count and no data_out.

Optional Feature:
FIFO_FWFT_EN
- Defined (first-word fall-through):
  - data_out = mem[rd_ptr], presented combinationally whenever !empty.
  - A word written into an empty FIFO appears on data_out on the edge where empty falls, i.e. one cycle after the write.
  - r_en acts as a pop acknowledge; after the pop edge data_out shows the next word.
  - data_out is don't-care while empty.
- Undefined: registered read with one-cycle latency, as described under Behaviour.

Test Plan:
All scenarios use DATA_W=8, DEPTH=8, AF_THRESH=6, AE_THRESH=2.
1. Reset, then idle -> empty=1, almost_empty=1, count=0, data_out=0, full=0, overflow=0, underflow=0.
2. Write 8 words A0..A7, one per cycle:
   - almost_empty falls when count=3.
   - almost_full rises when count=6.
   - full=1 when count=8.
   - Then read 8 -> data_out A0..A7 in order, each one cycle after its r_en; empty=1 after the last read.
3. With full, pulse w_en=1 alone, data B5 -> count stays 8, overflow=1, B5 is never read back; err_clr=1 for one cycle -> overflow=0.
4. With empty, pulse r_en=1 -> underflow=1, count=0, data_out unchanged. Then w_en=1 and r_en=1 together with data C1 -> count=1, underflow remains 1.
5. With full, assert w_en=1 and r_en=1 together for 20 cycles with incrementing data -> count stays 8, no overflow, output sequence contiguous and in order across pointer wrap.
6. FIFO_FWFT_EN defined: write D9 into an empty FIFO -> data_out=D9 on the next cycle with no r_en; then r_en=1 -> empty=1 and count=0.
